// File: rtl/rib_master_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rib_master_arbiter_pkg
// Description : Shared constants for the RIB master arbiter. Holds the bus
//               widths and the arbiter state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package rib_master_arbiter_pkg;

    // RIB bus widths
    localparam int c_RIB_ADDR_W = 32;
    localparam int c_RIB_DATA_W = 32;

    // Arbiter state encodings
    localparam int         c_RIB_ARB_STATE_W = 2;
    localparam logic [1:0] c_RIB_ARB_IDLE    = 2'd0;
    localparam logic [1:0] c_RIB_ARB_BUSY    = 2'd1;
    localparam logic [1:0] c_RIB_ARB_DONE    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rib_master_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rib_master_arbiter_rr_picker
// Description : Combinational round-robin picker. Searches the request
//               vector starting one position after i_ptr (wrapping modulo
//               NUM_MASTERS) and returns the first active requester.
// Ports       : i_req     - per-master request vector
//               i_ptr     - index of the most recently served master
//               o_valid   - at least one request is active
//               o_onehot  - one-hot winner
//               o_idx     - binary index of the winner
// Revision    : 1.0 - initial release
// ============================================================================
module rib_master_arbiter_rr_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_ptr,
    output logic                   o_valid,
    output logic [NUM_MASTERS-1:0] o_onehot,
    output logic [IDX_W-1:0]       o_idx
);

    logic [IDX_W-1:0] w_cand;

    // Candidates are visited in priority order ptr+1, ptr+2, ..., ptr; the
    // first active one wins. Visiting ptr last gives a lone requester
    // back-to-back service.
    always_comb begin
        o_valid  = 1'b0;
        o_onehot = '0;
        o_idx    = '0;
        w_cand   = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            w_cand = IDX_W'((int'(i_ptr) + i) % NUM_MASTERS);
            if (!o_valid && i_req[w_cand]) begin
                o_valid          = 1'b1;
                o_onehot[w_cand] = 1'b1;
                o_idx            = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rib_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rib_master_arbiter
// Description : Round-robin arbiter sharing the RIB system bus among up to
//               NUM_MASTERS masters (master 0 = core LSU). One transaction
//               at a time: IDLE (arbitrate) -> BUSY (wait for slave ack)
//               -> DONE (one-cycle grant pulse to the owner).
//               Optional watchdog enabled by defining RIB_ARB_TIMEOUT_EN:
//               a BUSY period of TIMEOUT_CYCLES cycles without ack is
//               completed with zero read data and an m_err_o pulse.
// Ports       : clk, rst (asynchronous, active low)
//               m_req_i/m_we_i     - per-master request / write enable
//               m_addr_i/m_wdata_i - per-master address / write data,
//                                    master k at [32k+31:32k]
//               m_gnt_o            - one-hot completion pulse
//               m_rdata_o          - read data, valid with own m_gnt_o
//               m_err_o            - timeout flag, pulses with m_gnt_o
//               s_req_o/s_we_o/s_addr_o/s_wdata_o - request to decoder
//               s_ack_i/s_rdata_i  - slave completion and read data
//               hold_o             - stall core while a debug master owns
//                                    the bus
// Revision    : 1.0 - initial release
// ============================================================================
module rib_master_arbiter
    import rib_master_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_MASTERS-1:0]              m_req_i,
    input  logic [NUM_MASTERS-1:0]              m_we_i,
    input  logic [NUM_MASTERS*c_RIB_ADDR_W-1:0] m_addr_i,
    input  logic [NUM_MASTERS*c_RIB_DATA_W-1:0] m_wdata_i,
    output logic [NUM_MASTERS-1:0]              m_gnt_o,
    output logic [c_RIB_DATA_W-1:0]             m_rdata_o,
    output logic                                m_err_o,
    output logic                                s_req_o,
    output logic                                s_we_o,
    output logic [c_RIB_ADDR_W-1:0]             s_addr_o,
    output logic [c_RIB_DATA_W-1:0]             s_wdata_o,
    input  logic                                s_ack_i,
    input  logic [c_RIB_DATA_W-1:0]             s_rdata_i,
    output logic                                hold_o
);

    localparam int                 c_IDX_W   = $clog2(NUM_MASTERS);
    // Pointer resets to the last master so master 0 is searched first.
    localparam logic [c_IDX_W-1:0] c_PTR_RST = c_IDX_W'(NUM_MASTERS - 1);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("rib_master_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    // ------------------------------------------------------------------
    // Unpack per-master address / write data buses
    // ------------------------------------------------------------------
    logic [c_RIB_ADDR_W-1:0] w_addr  [NUM_MASTERS];
    logic [c_RIB_DATA_W-1:0] w_wdata [NUM_MASTERS];

    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
        assign w_addr[k]  = m_addr_i[k*c_RIB_ADDR_W +: c_RIB_ADDR_W];
        assign w_wdata[k] = m_wdata_i[k*c_RIB_DATA_W +: c_RIB_DATA_W];
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [c_RIB_ARB_STATE_W-1:0] r_state;
    logic [c_RIB_ARB_STATE_W-1:0] w_state_next;
    logic [c_IDX_W-1:0]           r_owner;
    logic [NUM_MASTERS-1:0]       r_owner_oh;
    logic [c_IDX_W-1:0]           r_ptr;
    logic [c_RIB_DATA_W-1:0]      r_rdata;
    logic                         r_err;

    logic                         w_pick_valid;
    logic [NUM_MASTERS-1:0]       w_pick_onehot;
    logic [c_IDX_W-1:0]           w_pick_idx;
    logic                         w_owner_we;
    logic                         w_ack_done;
    logic                         w_tmo;
    logic                         w_wdog_hit;

    rib_master_arbiter_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (c_IDX_W)
    ) u_rr_picker (
        .i_req    (m_req_i),
        .i_ptr    (r_ptr),
        .o_valid  (w_pick_valid),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx)
    );

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef RIB_ARB_TIMEOUT_EN
    localparam int c_WDOG_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [c_WDOG_W-1:0] r_wdog;

    // Held at zero while IDLE so every BUSY period starts from zero; counts
    // BUSY cycles that end without an ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog <= '0;
        end else if (r_state == c_RIB_ARB_IDLE) begin
            r_wdog <= '0;
        end else if (r_state == c_RIB_ARB_BUSY && !s_ack_i) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    // The current BUSY cycle is the TIMEOUT_CYCLES-th one without an ack.
    assign w_wdog_hit = (r_wdog == c_WDOG_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_wdog_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_ack_done   = 1'b0;
        w_tmo        = 1'b0;
        case (r_state)
            c_RIB_ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_state_next = c_RIB_ARB_BUSY;
                end
            end
            c_RIB_ARB_BUSY: begin
                // An ack in the timeout cycle wins over the timeout.
                if (s_ack_i) begin
                    w_ack_done   = 1'b1;
                    w_state_next = c_RIB_ARB_DONE;
                end else if (w_wdog_hit) begin
                    w_tmo        = 1'b1;
                    w_state_next = c_RIB_ARB_DONE;
                end
            end
            c_RIB_ARB_DONE: begin
                w_state_next = c_RIB_ARB_IDLE;
            end
            default: begin
                w_state_next = c_RIB_ARB_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, ownership and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_RIB_ARB_IDLE;
            r_owner    <= '0;
            r_owner_oh <= NUM_MASTERS'(1);
            r_ptr      <= c_PTR_RST;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == c_RIB_ARB_IDLE && w_pick_valid) begin
                r_owner    <= w_pick_idx;
                r_owner_oh <= w_pick_onehot;
            end
            if (w_ack_done) begin
                r_rdata <= w_owner_we ? '0 : s_rdata_i;
                r_err   <= 1'b0;
                r_ptr   <= r_owner;
            end else if (w_tmo) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
                r_ptr   <= r_owner;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_owner_we = m_we_i[r_owner];

    assign s_req_o    = (r_state == c_RIB_ARB_BUSY);
    assign s_we_o     = w_owner_we;
    assign s_addr_o   = w_addr[r_owner];
    assign s_wdata_o  = w_wdata[r_owner];

    assign m_gnt_o    = (r_state == c_RIB_ARB_DONE) ? r_owner_oh : '0;
    assign m_rdata_o  = r_rdata;
    assign m_err_o    = (r_state == c_RIB_ARB_DONE) && r_err;

    assign hold_o     = (r_state != c_RIB_ARB_IDLE) && (r_owner != '0);

endmodule
`default_nettype wire

// File: tb/tb_rib_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rib_master_arbiter
// Description : Self-checking bench for rib_master_arbiter. Masters and a
//               slave are driven with $urandom traffic; a transaction-level
//               model predicts every cycle's bus view and grants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rib_master_arbiter;

    localparam int N = 4;
`ifdef RIB_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 255;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    m_req = '0;
    logic [N-1:0]    m_we = '0;
    logic [N*32-1:0] m_addr = '0;
    logic [N*32-1:0] m_wdata = '0;
    logic [N-1:0]    m_gnt;
    logic [31:0]     m_rdata;
    logic            m_err;
    logic            s_req;
    logic            s_we;
    logic [31:0]     s_addr;
    logic [31:0]     s_wdata;
    logic            s_ack = 1'b0;
    logic [31:0]     s_rdata = '0;
    logic            hold;

    rib_master_arbiter #(
        .NUM_MASTERS    (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_req_i   (m_req),
        .m_we_i    (m_we),
        .m_addr_i  (m_addr),
        .m_wdata_i (m_wdata),
        .m_gnt_o   (m_gnt),
        .m_rdata_o (m_rdata),
        .m_err_o   (m_err),
        .s_req_o   (s_req),
        .s_we_o    (s_we),
        .s_addr_o  (s_addr),
        .s_wdata_o (s_wdata),
        .s_ack_i   (s_ack),
        .s_rdata_i (s_rdata),
        .hold_o    (hold)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Master-side transactions
    bit          pend [N];
    bit          rq   [N];
    bit          we_a [N];
    logic [31:0] addr_a  [N];
    logic [31:0] wdata_a [N];
    int          gnt_seen [N];

    // Reference model: who owns the bus, who is being granted, last served
    int          busy = -1;
    int          gnt_to = -1;
    int          last = N - 1;
    int          wcnt = 0;
    bit          err_exp = 1'b0;
    logic [31:0] rdata_exp = '0;

    // Stimulus knobs
    logic [N-1:0] allow = '0;
    bit           all_mode = 1'b0;
    int           new_pct = 0;
    int           ack_pct = 50;
    int           spur_pct = 0;
    int           drop_pct = 0;
    int           force_wait = -1;
    logic [31:0]  force_rd = '0;
    bit           use_force_rd = 1'b0;

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            m_req[k]             = rq[k];
            m_we[k]              = we_a[k];
            m_addr[32*k +: 32]   = addr_a[k];
            m_wdata[32*k +: 32]  = wdata_a[k];
        end
    endtask

    task automatic set_txn(input int k, input bit we, input logic [31:0] a, input logic [31:0] d);
        pend[k] = 1'b1;
        rq[k] = 1'b1;
        we_a[k] = we;
        addr_a[k] = a;
        wdata_a[k] = d;
    endtask

    task automatic model_reset();
        busy = -1;
        gnt_to = -1;
        last = N - 1;
        wcnt = 0;
        err_exp = 1'b0;
        rdata_exp = '0;
    endtask

    // Advance the model by one clock edge given the inputs the DUT will see.
    task automatic model_step(input bit ack, input logic [31:0] rd);
        int kk;
        if (gnt_to >= 0) begin
            gnt_to = -1;
            err_exp = 1'b0;
        end else if (busy >= 0) begin
            if (ack) begin
                rdata_exp = we_a[busy] ? 32'h0 : rd;
                err_exp = 1'b0;
                last = busy;
                gnt_to = busy;
                busy = -1;
            end else begin
                wcnt++;
`ifdef RIB_ARB_TIMEOUT_EN
                if (wcnt == TMO) begin
                    rdata_exp = 32'h0;
                    err_exp = 1'b1;
                    last = busy;
                    gnt_to = busy;
                    busy = -1;
                end
`endif
            end
        end else begin
            for (int i = 1; i <= N; i++) begin
                kk = (last + i) % N;
                if (rq[kk]) begin
                    busy = kk;
                    wcnt = 0;
                    break;
                end
            end
        end
    endtask

    // One clock: compare outputs against the model, choose new inputs,
    // advance the model.
    task automatic cycle();
        logic [N-1:0] exp_gnt;
        bit           ack;
        logic [31:0]  rd;
        @(negedge clk);
        exp_gnt = '0;
        if (gnt_to >= 0) exp_gnt[gnt_to] = 1'b1;
        check("gnt", 32'(m_gnt), 32'(exp_gnt));
        check("s_req", 32'(s_req), (busy >= 0) ? 32'd1 : 32'd0);
        check("hold", 32'(hold), ((busy > 0) || (gnt_to > 0)) ? 32'd1 : 32'd0);
        check("err", 32'(m_err), ((gnt_to >= 0) && err_exp) ? 32'd1 : 32'd0);
        if (busy >= 0) begin
            check("s_we", 32'(s_we), 32'(we_a[busy]));
            check("s_addr", s_addr, addr_a[busy]);
            check("s_wdata", s_wdata, wdata_a[busy]);
        end
        if (gnt_to >= 0) begin
            check("rdata", m_rdata, rdata_exp);
        end
        for (int k = 0; k < N; k++) begin
            if (m_gnt[k]) gnt_seen[k]++;
        end

        // Masters
        if (gnt_to >= 0) begin
            pend[gnt_to] = 1'b0;
            rq[gnt_to] = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            if (!pend[k] && allow[k] && (all_mode || ($urandom_range(99) < new_pct))) begin
                set_txn(k, 1'($urandom_range(1)), $urandom(), $urandom());
            end else if (pend[k] && busy == k && rq[k] && ($urandom_range(99) < drop_pct)) begin
                rq[k] = 1'b0;
            end
        end

        // Slave
        if (busy >= 0) begin
            ack = (force_wait >= 0) ? (wcnt == force_wait) : ($urandom_range(99) < ack_pct);
        end else begin
            ack = ($urandom_range(99) < spur_pct);
        end
        rd = use_force_rd ? force_rd : $urandom();
        s_ack = ack;
        s_rdata = rd;
        drive_inputs();
        model_step(ack, rd);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain();
        int guard;
        allow = '0;
        all_mode = 1'b0;
        force_wait = -1;
        ack_pct = 60;
        spur_pct = 0;
        drop_pct = 0;
        guard = 0;
        while ((busy >= 0 || gnt_to >= 0 || pend[0] || pend[1] || pend[2] || pend[3]) && guard < 200) begin
            cycle();
            guard++;
        end
        check("drain_done", 32'(guard < 200), 32'd1);
        run(2);
    endtask

    initial begin
        int g0;
        int guard;
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0;
            rq[k] = 1'b0;
            we_a[k] = 1'b0;
            addr_a[k] = '0;
            wdata_a[k] = '0;
            gnt_seen[k] = 0;
        end
        drive_inputs();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(m_gnt), 32'd0);
        check("rst_rdata", m_rdata, 32'd0);
        check("rst_err", 32'(m_err), 32'd0);
        check("rst_sreq", 32'(s_req), 32'd0);
        check("rst_hold", 32'(hold), 32'd0);
        rst = 1'b1;
        model_reset();
        model_step(1'b0, 32'h0);

        // Master 0 read, slave acks after 2 wait cycles
        set_txn(0, 1'b0, 32'h1000_0004, 32'h0);
        drive_inputs();
        model_step(1'b0, 32'h0);
        force_wait = 2;
        use_force_rd = 1'b1;
        force_rd = 32'hA5A5_0001;
        g0 = gnt_seen[0];
        run(8);
        check("m0_read_once", 32'(gnt_seen[0] - g0), 32'd1);
        use_force_rd = 1'b0;

        // Master 1 write, non-zero bus rdata must not leak into m_rdata_o
        set_txn(1, 1'b1, 32'h2000_0000, 32'hDEAD_BEEF);
        force_wait = 1;
        run(8);

        // All masters requesting continuously, zero-wait slave
        allow = '1;
        all_mode = 1'b1;
        force_wait = 0;
        run(40);
        drain();

        // Spurious acks while idle, then one normal transaction
        spur_pct = 100;
        run(4);
        g0 = gnt_seen[3];
        set_txn(3, 1'b0, 32'h3000_0010, 32'h0);
        force_wait = 1;
        run(12);
        check("spur_once", 32'(gnt_seen[3] - g0), 32'd1);
        drain();

        // Reset in the second BUSY cycle of a master 2 transfer
        set_txn(2, 1'b0, 32'h4000_0000, 32'h0);
        ack_pct = 0;
        force_wait = -1;
        guard = 0;
        while (busy != 2 && guard < 10) begin
            cycle();
            guard++;
        end
        check("m2_busy", 32'(busy == 2), 32'd1);
        cycle();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_sreq", 32'(s_req), 32'd0);
        check("mid_rst_hold", 32'(hold), 32'd0);
        check("mid_rst_gnt", 32'(m_gnt), 32'd0);
        check("mid_rst_rdata", m_rdata, 32'd0);
        model_reset();
        set_txn(0, 1'b0, 32'h1000_0008, 32'h0);
        s_ack = 1'b0;
        drive_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_step(1'b0, 32'h0);
        ack_pct = 60;
        run(12);
        drain();

`ifdef RIB_ARB_TIMEOUT_EN
        // Slave never acks: both requesters time out in turn
        set_txn(1, 1'b0, 32'h5000_0000, 32'h0);
        set_txn(3, 1'b1, 32'h5000_0004, 32'h1234_5678);
        ack_pct = 0;
        force_wait = -1;
        run(45);
        // Ack arriving in the timeout cycle completes normally
        set_txn(2, 1'b0, 32'h6000_0000, 32'h0);
        force_wait = TMO - 1;
        run(25);
        drain();
`endif

        // Randomised traffic
        allow = '1;
        all_mode = 1'b0;
        new_pct = 40;
        ack_pct = 50;
        spur_pct = 20;
        drop_pct = 10;
        force_wait = -1;
        run(1500);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
